// File: rtl/prog_sequencer_if.sv
// Request/grant and SPI-side signals of the programmer sequencer.
// master: requesters and programmer side; slave: the sequencer itself.
interface prog_sequencer_if #(
    parameter int NUM_BITS = 58
);
    logic                req0;
    logic                req1;
    logic [NUM_BITS-1:0] data0;
    logic [NUM_BITS-1:0] data1;
    logic                ack0;
    logic                ack1;
    logic                busy;
    logic                done;
    logic                spi_sclk;
    logic                spi_sdi;
    logic                spi_cs_n;

    modport master (
        output req0, req1, data0, data1,
        input  ack0, ack1, busy, done, spi_sclk, spi_sdi, spi_cs_n
    );

    modport slave (
        input  req0, req1, data0, data1,
        output ack0, ack1, busy, done, spi_sclk, spi_sdi, spi_cs_n
    );
endinterface

// File: rtl/prog_sequencer.sv
// Round-robin arbiter feeding a mode-0 SPI frame shifter; ack one cycle after a pending request in IDLE.
// Requests are level-held and only looked at in IDLE; cs_n low for (2*NUM_BITS+2)*HALF_DIV cycles per frame.
module prog_sequencer #(
    parameter int NUM_BITS = 58,
    parameter int HALF_DIV = 2,
    parameter int CS_GAP   = 4
) (
    input  logic            SCLK,
    input  logic            reset,
    prog_sequencer_if.slave bus
);
    localparam int BCNT_W  = $clog2(NUM_BITS + 1);
    localparam int DIV_MAX = (HALF_DIV > CS_GAP) ? HALF_DIV : CS_GAP;
    localparam int DIV_W   = $clog2(DIV_MAX + 1);

    localparam logic [DIV_W-1:0]  HALF_LAST = DIV_W'(HALF_DIV - 1);
    localparam logic [DIV_W-1:0]  GAP_LAST  = DIV_W'(CS_GAP - 1);
    localparam logic [BCNT_W-1:0] BIT_LAST  = BCNT_W'(NUM_BITS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [BCNT_W-1:0]   bit_q, bit_d;
    logic                phase_q, phase_d;
    logic [NUM_BITS-1:0] shreg_q, shreg_d;
    logic                rr_q, rr_d;
    logic                ack0_q, ack0_d;
    logic                ack1_q, ack1_d;

    always_ff @(posedge SCLK or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            phase_q <= 1'b0;
            shreg_q <= '0;
            rr_q    <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            phase_q <= phase_d;
            shreg_q <= shreg_d;
            rr_q    <= rr_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q + 1'b1;
        bit_d   = bit_q;
        phase_d = phase_q;
        shreg_d = shreg_q;
        rr_d    = rr_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        case (state_q)
            IDLE: begin
                div_d   = '0;
                bit_d   = '0;
                phase_d = 1'b0;
                // rr_q names the requester that wins a tie: the one not served last
                if (bus.req0 && (!bus.req1 || !rr_q)) begin
                    ack0_d  = 1'b1;
                    shreg_d = bus.data0;
                    rr_d    = 1'b1;
                    state_d = SETUP;
                end else if (bus.req1) begin
                    ack1_d  = 1'b1;
                    shreg_d = bus.data1;
                    rr_d    = 1'b0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (div_q == HALF_LAST) begin
                    div_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // each bit is a low half then a high half; the falling edge shifts
                if (div_q == HALF_LAST) begin
                    div_d = '0;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        shreg_d = shreg_q >> 1;
                        bit_d   = bit_q + 1'b1;
                        if (bit_q == BIT_LAST) begin
                            state_d = HOLD;
                        end
                    end
                end
            end
            HOLD: begin
                if (div_q == HALF_LAST) begin
                    div_d   = '0;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (div_q == GAP_LAST) begin
                    div_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                div_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.busy     = (state_q != IDLE);
        bus.spi_cs_n = 1'b1;
        bus.spi_sclk = 1'b0;
        bus.spi_sdi  = 1'b0;
        bus.done     = 1'b0;
        bus.ack0     = ack0_q;
        bus.ack1     = ack1_q;
        case (state_q)
            SETUP, HOLD: begin
                bus.spi_cs_n = 1'b0;
                bus.spi_sdi  = shreg_q[0];
            end
            SHIFT: begin
                bus.spi_cs_n = 1'b0;
                bus.spi_sclk = phase_q;
                bus.spi_sdi  = shreg_q[0];
            end
            GAP: begin
                bus.done = (div_q == '0);
            end
            default: begin
            end
        endcase
    end
endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer: requester/programmer models plus a frame-level reference.
// Directed scenarios (reset, loopback, arbitration, late request, mid-frame reset) then random traffic.
module tb_prog_sequencer;
    localparam int NB      = 58;
    localparam int HD      = 2;
    localparam int CG      = 4;
    localparam int LOW_CYC = (2 * NB + 2) * HD;

    typedef logic [NB-1:0] pay_t;

    logic SCLK  = 1'b0;
    logic reset = 1'b0;
    always #5 SCLK = ~SCLK;

    prog_sequencer_if #(.NUM_BITS(NB)) seq_bus ();

    prog_sequencer #(
        .NUM_BITS(NB),
        .HALF_DIV(HD),
        .CS_GAP  (CG)
    ) u_dut (
        .SCLK (SCLK),
        .reset(reset),
        .bus  (seq_bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic pay_t rand_pay();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[NB-1:0];
    endfunction

    // Reference state: pending payloads per requester, acked frames awaiting
    // completion, tie-break preference, and the programmer's committed frame.
    pay_t        q0[$];
    pay_t        q1[$];
    pay_t        exp_q[$];
    int          ack_log[$];
    logic        pref = 1'b0;
    logic        win_exp;
    logic        in_frame = 1'b0;
    int          lowcnt = 0;
    int          nrise = 0;
    logic [63:0] bits = '0;
    logic        p_sclk = 1'b0, p_sdi = 1'b0, p_cs = 1'b1;
    logic        p_req0 = 1'b0, p_req1 = 1'b0, p_busy = 1'b0;
    logic        gap_on = 1'b0;
    int          gap_cnt = 0;
    pay_t        prog_frame = '0;
    int          frames_done = 0;

    initial begin
        seq_bus.req0  = 1'b0;
        seq_bus.req1  = 1'b0;
        seq_bus.data0 = '0;
        seq_bus.data1 = '0;
        forever begin
            @(negedge SCLK);
            if (!reset) begin
                chk("rst_cs_n", seq_bus.spi_cs_n, 1);
                chk("rst_sclk_sdi", {seq_bus.spi_sclk, seq_bus.spi_sdi}, 0);
                chk("rst_busy_done", {seq_bus.busy, seq_bus.done}, 0);
                chk("rst_acks", {seq_bus.ack1, seq_bus.ack0}, 0);
                in_frame = 1'b0;
                gap_on   = 1'b0;
                pref     = 1'b0;
                exp_q.delete();
            end else begin
                if (seq_bus.ack0 || seq_bus.ack1) begin
                    win_exp = (p_req0 && p_req1) ? pref : !p_req0;
                    chk("ack_had_req", p_req0 | p_req1, 1);
                    chk("ack_while_idle", p_busy, 0);
                    chk("ack_winner", {seq_bus.ack1, seq_bus.ack0}, win_exp ? 2'b10 : 2'b01);
                    pref = !win_exp;
                    ack_log.push_back(seq_bus.ack1 ? 1 : 0);
                    if (seq_bus.ack1 && q1.size() > 0) exp_q.push_back(q1.pop_front());
                    else if (seq_bus.ack0 && q0.size() > 0) exp_q.push_back(q0.pop_front());
                end
                if (!seq_bus.spi_cs_n) begin
                    if (p_cs) begin
                        in_frame = 1'b1;
                        lowcnt   = 0;
                        nrise    = 0;
                        bits     = '0;
                    end
                    lowcnt++;
                    if (seq_bus.spi_sclk && !p_sclk) begin
                        if (nrise < 64) bits[nrise] = seq_bus.spi_sdi;
                        chk("sdi_stable_at_rise", seq_bus.spi_sdi, p_sdi);
                        nrise++;
                    end
                end else if (!p_cs && in_frame) begin
                    in_frame = 1'b0;
                    chk("cs_low_cycles", lowcnt, LOW_CYC);
                    chk("sclk_rises", nrise, NB);
                    chk("done_at_cs_rise", seq_bus.done, 1);
                    if (exp_q.size() > 0) chk("frame_bits", bits[NB-1:0], exp_q.pop_front());
                    else chk("frame_was_acked", 0, 1);
                    prog_frame = bits[NB-1:0];
                    frames_done++;
                    gap_on  = 1'b1;
                    gap_cnt = 1;
                end else begin
                    chk("idle_sclk_sdi", {seq_bus.spi_sclk, seq_bus.spi_sdi}, 0);
                    chk("done_quiet", seq_bus.done, 0);
                    if (gap_on) begin
                        if (seq_bus.busy) begin
                            gap_cnt++;
                        end else begin
                            chk("gap_cycles", gap_cnt, CG);
                            gap_on = 1'b0;
                        end
                    end
                end
            end
            // requesters: hold req until acked, then scramble the bus data
            if (seq_bus.ack0) begin
                seq_bus.req0  = 1'b0;
                seq_bus.data0 = rand_pay();
            end
            if (seq_bus.ack1) begin
                seq_bus.req1  = 1'b0;
                seq_bus.data1 = rand_pay();
            end
            if (!seq_bus.req0 && q0.size() > 0) begin
                seq_bus.req0  = 1'b1;
                seq_bus.data0 = q0[0];
            end
            if (!seq_bus.req1 && q1.size() > 0) begin
                seq_bus.req1  = 1'b1;
                seq_bus.data1 = q1[0];
            end
            p_sclk = seq_bus.spi_sclk;
            p_sdi  = seq_bus.spi_sdi;
            p_cs   = seq_bus.spi_cs_n;
            p_busy = seq_bus.busy;
            p_req0 = seq_bus.req0;
            p_req1 = seq_bus.req1;
        end
    end

    task automatic wait_drain(input int limit);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || exp_q.size() > 0 || seq_bus.busy ||
                gap_on || seq_bus.req0 || seq_bus.req1) && n < limit) begin
            @(negedge SCLK);
            n++;
        end
        chk("drain_in_time", n < limit, 1);
        @(negedge SCLK);
    endtask

    task automatic wait_rise(input int k, input int limit);
        int n = 0;
        while (!(in_frame && nrise >= k) && n < limit) begin
            @(negedge SCLK);
            n++;
        end
        chk("rise_reached", n < limit, 1);
    endtask

    task automatic pulse_reset();
        @(negedge SCLK);
        #1 reset = 1'b0;
        repeat (2) @(negedge SCLK);
        #1 reset = 1'b1;
    endtask

    initial begin
        int   f0;
        pay_t tmp;

        // reset held with req0 pending, then ack0 right after release
        q0.push_back(58'h2A5_5AA5_F00F_1234);
        repeat (4) @(negedge SCLK);
        #1 chk("no_ack_in_reset", seq_bus.ack0, 0);
        reset = 1'b1;
        @(negedge SCLK);
        #1 chk("ack0_after_release", seq_bus.ack0, 1);
        wait_drain(2000);
        chk("first_frame_count", frames_done, 1);

        // loopback into the programmer's register fields
        q0.push_back(58'h000_0000_0000_F0A5);
        wait_drain(2000);
        chk("GTHDR", prog_frame[7:0], 8'hA5);
        chk("GTHSNR", prog_frame[15:8], 8'hF0);
        chk("prog_other_fields", prog_frame[NB-1:16], 0);

        // three rounds of simultaneous requests from a fresh pointer
        pulse_reset();
        ack_log.delete();
        for (int i = 0; i < 3; i++) begin
            q0.push_back(rand_pay());
            q1.push_back(rand_pay());
            wait_drain(4000);
        end
        chk("rr_log_len", ack_log.size(), 6);
        for (int i = 0; i < ack_log.size() && i < 6; i++) chk("rr_order", ack_log[i], i % 2);

        // req1 raised mid-frame is held off until IDLE
        ack_log.delete();
        q0.push_back(rand_pay());
        wait_rise(10, 1000);
        q1.push_back(rand_pay());
        wait_drain(4000);
        chk("late_req_len", ack_log.size(), 2);
        if (ack_log.size() == 2) chk("late_req_order", {ack_log[0][0], ack_log[1][0]}, 2'b01);

        // reset at the 20th rise aborts the frame; next frame is complete
        f0 = frames_done;
        q0.push_back(rand_pay());
        wait_rise(20, 1000);
        #1 reset = 1'b0;
        #1 chk("abort_cs_n", seq_bus.spi_cs_n, 1);
        chk("abort_sclk", seq_bus.spi_sclk, 0);
        tmp = rand_pay();
        q0.push_back(tmp);
        repeat (2) @(negedge SCLK);
        #1 reset = 1'b1;
        wait_drain(2000);
        chk("abort_frames", frames_done - f0, 1);
        chk("restart_payload", prog_frame, tmp);

        // random traffic
        for (int i = 0; i < 16; i++) begin
            int r;
            r = $urandom_range(1, 3);
            if (r[0]) q0.push_back(rand_pay());
            if (r[1]) q1.push_back(rand_pay());
            repeat ($urandom_range(0, 300)) @(negedge SCLK);
        end
        wait_drain(20000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/prog_sequencer.md
PROG_SEQUENCER -- requirements
Module: prog_sequencer

Interface
REQ-001 Parameter NUM_BITS, default 58, meaning: configuration frame length in bits.
REQ-002 Parameter HALF_DIV, default 2, meaning: SCLK cycles per spi_sclk half-period; legal range is 1 or more.
REQ-003 Parameter CS_GAP, default 4, meaning: SCLK cycles spi_cs_n stays high between consecutive frames; legal range is 1 or more.
REQ-004 SCLK  input  1  system clock; all state updates on its rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-low.
REQ-006 req0 / req1  input  1 each  requester 0 / requester 1 frame request; level, held until the matching ack.
REQ-007 data0 / data1  input  NUM_BITS each  frame payload for requester 0 / 1; bit i lands in downstream shift bit i.
REQ-008 ack0 / ack1  output  1 each  one-cycle grant pulse; the payload is captured in the same cycle.
REQ-009 busy  output  1  high whenever the state is not IDLE.
REQ-010 done  output  1  one-cycle pulse in the cycle spi_cs_n rises at the end of a frame.
REQ-011 spi_sclk  output  1  serial clock to the programmer, SPI mode 0, idles low.
REQ-012 spi_sdi  output  1  serial data to the programmer.
REQ-013 spi_cs_n  output  1  programmer chip select, active-low; its rising edge commits the frame.

Function
REQ-014 The block SHALL implement these states: IDLE, SETUP, SHIFT, HOLD and GAP.
REQ-015 In IDLE, when req0 or req1 is high, the block SHALL grant exactly one requester: pulse its ack, load its data into the shift register, and enter SETUP on the next cycle.
REQ-016 Arbitration when both requests are high SHALL be round-robin: the requester not granted last wins; after reset, requester 0 wins.
REQ-017 Requests seen while busy SHALL NOT be acked; they SHALL be evaluated only on return to IDLE.
REQ-018 On entry to SETUP, spi_cs_n SHALL go low and spi_sdi SHALL present payload bit 0; SETUP SHALL last HALF_DIV cycles with spi_sclk low.
REQ-019 In SHIFT, spi_sclk SHALL toggle every HALF_DIV cycles, starting with a rising edge.
REQ-020 On each falling edge of spi_sclk, spi_sdi SHALL advance to the next payload bit, LSB first.
REQ-021 spi_sdi SHALL be stable across every spi_sclk rising edge.
REQ-022 SHIFT SHALL end exactly at the NUM_BITS-th falling edge of spi_sclk, giving exactly NUM_BITS rising edges per frame.
REQ-023 HOLD SHALL keep spi_sclk low for HALF_DIV cycles.
REQ-024 At the end of HOLD, spi_cs_n SHALL go high and done SHALL pulse in that same cycle, followed by GAP.
REQ-025 spi_cs_n low time SHALL be exactly (2*NUM_BITS+2)*HALF_DIV SCLK cycles, which is 236 cycles at the defaults.
REQ-026 GAP SHALL hold spi_cs_n high and spi_sclk low for CS_GAP cycles, then enter IDLE.
REQ-027 The bit counter SHALL be sized ceil(log2(NUM_BITS+1)) bits and SHALL NOT wrap within a frame.
REQ-028 The divider counter SHALL restart at every state entry.
REQ-029 spi_sdi SHALL be 0 in IDLE and GAP.
REQ-030 spi_cs_n SHALL never pulse low for a partial frame under normal operation; only reset may abort a frame.

Reset
REQ-031 Asserting reset at any time SHALL asynchronously force the outputs to: state IDLE, spi_cs_n=1, spi_sclk=0, spi_sdi=0, ack0=ack1=0, done=0, busy=0, shift register=0, and round-robin pointer to requester 0.
REQ-032 The programmer SHALL share the same reset net, so a spi_cs_n rise caused by reset mid-frame commits nothing.
REQ-033 After reset deassertion, the first cycle with a request pending SHALL produce an ack.

Verification
REQ-034 Reset check: assert reset with req0 held high -> all outputs hold their reset values and no ack is issued; after release, ack0 pulses within 1 cycle.
REQ-035 Single frame at defaults with data0=58'h2A5_5AA5_F00F_1234 -> spi_cs_n low for 236 cycles, 58 spi_sclk rising edges, sampled bits equal data0 LSB first, one done pulse, then 4 gap cycles.
REQ-036 req0 and req1 high together twice in a row -> grant order ack0, ack1; on a third simultaneous request immediately after, grant order ack0 then ack1 again under the alternating pointer.
REQ-037 req1 raised at bit 10 of a requester-0 frame -> no ack1 until IDLE; ack1 follows the GAP, and its frame carries data1 unchanged even if data1 changes after the ack.
REQ-038 Reset asserted at the 20th spi_sclk rise -> spi_cs_n=1 and spi_sclk=0 immediately; after release, a new frame starts from bit 0 with a full 236-cycle spi_cs_n low time.
REQ-039 Loopback into a programmer instance with data0=58'h000_0000_0000_F0A5 -> GTHDR=8'hA5 and GTHSNR=8'hF0 after the done pulse, with all other fields 0.
